// File: rtl/regfile.sv
// 32 x WIDTH register file: two combinational read ports and one write port.
// X31 reads as zero; same-cycle writes are forwarded to matching read ports.
module regfile #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_en,
    input  logic [4:0]       write_reg,
    input  logic [WIDTH-1:0] write_data,
    input  logic [4:0]       read_reg1,
    input  logic [4:0]       read_reg2,
    output logic [WIDTH-1:0] read_data1,
    output logic [WIDTH-1:0] read_data2
);

    logic [30:0]      wr_sel;
    logic [WIDTH-1:0] rf_view [0:31];

    genvar gi;
    generate
        for (gi = 0; gi < 31; gi++) begin : g_reg
            logic [WIDTH-1:0] x_q;
            logic [WIDTH-1:0] x_d;

            assign wr_sel[gi] = write_en && (write_reg == 5'(gi));
            assign x_d        = wr_sel[gi] ? write_data : x_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    x_q <= '0;
                end else begin
                    x_q <= x_d;
                end
            end

            assign rf_view[gi] = x_q;
        end
    endgenerate

    // X31 has no storage; its mux input is tied low, so writes to it are discarded.
    assign rf_view[31] = '0;

    logic [4:0]       rd_addr [0:1];
    logic [WIDTH-1:0] rd_data [0:1];

    assign rd_addr[0] = read_reg1;
    assign rd_addr[1] = read_reg2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic bypass;
            assign bypass = write_en && !reset && (write_reg == rd_addr[gi])
                            && (rd_addr[gi] != 5'd31);
            assign rd_data[gi] = bypass ? write_data : rf_view[rd_addr[gi]];
        end
    endgenerate

    assign read_data1 = rd_data[0];
    assign read_data2 = rd_data[1];

endmodule
